// File: rtl/cla_sub_serial.sv
// Serial subtractor: D = A - B - bin, one 4-bit carry-lookahead slice per clock, LSB first.
// Latency: result valid NSLICE cycles after the accept edge; one op per NSLICE+2 cycles at best.
// Backpressure: in_ready low while busy; result, bout and zero hold in DONE until out_ready.
module cla_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, d_q, d_nxt;
    logic             borrow, bout_q, zero_q;
    logic [IW-1:0]    idx;
    logic [IW+1:0]    base;
    logic [3:0]       a_s, nb_s, p, g, ds;
    logic [4:0]       c;
    logic             accept, step;

    assign base = {idx, 2'b00};

    // Subtraction as A + ~B + carry-in, where carry-in is the inverted running borrow.
    always_comb begin
        a_s  = a_q[base +: 4];
        nb_s = ~b_q[base +: 4];
        p    = a_s ^ nb_s;
        g    = a_s & nb_s;
        c[0] = ~borrow;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        ds   = p ^ c[3:0];
        d_nxt = d_q;
        d_nxt[base +: 4] = ds;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // bout/zero only change on the final slice so they hold the last result until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                borrow <= bin;
                idx    <= '0;
            end
            if (step) begin
                d_q    <= d_nxt;
                borrow <= ~c[4];
                idx    <= idx + IW'(1);
                if (idx == LAST) begin
                    bout_q <= ~c[4];
                    zero_q <= (d_nxt == '0);
                end
            end
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: doc/cla_sub_serial.md
Name: cla_sub_serial

Overview:
- Multi-cycle unsigned subtractor: computes D = A − B − bin one 4-bit slice per clock, LSB slice first.
- Each slice uses carry-lookahead logic on A and inverted B, so A − B − bin = A + ~B + (1 − bin).
- A registered borrow links consecutive slices.
- Valid/ready handshakes on both sides; sits alongside the team's CLA adder blocks as the inverse arithmetic unit.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NSLICE, WIDTH/4, derived local value: slices per operation; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference, modulo 2^WIDTH
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned)
- zero  output  1  d == 0

Behaviour:
- Reset: the asynchronous assert of rst_n forces the following state immediately.
  - state = IDLE, in_ready = 1, out_valid = 0
  - d = 0, bout = 0, zero = 0
  - slice index = 0, captured operands cleared
- FSM: IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a clock edge: capture a, b, bin; set borrow = bin, index = 0; go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle processes slice i = index, bits [4i+3:4i]:
    - p = a_s ^ ~b_s, g = a_s & ~b_s, c0 = ~borrow.
    - Carries c1..c4 come from full two-level lookahead (no ripple inside the slice).
    - d_s = p ^ {c3, c2, c1, c0}.
    - New borrow = ~c4.
  - At the edge, d_s is written into slice i of the result register, borrow is updated, and index increments.
  - After the slice with index NSLICE−1 is written, go to DONE.
- DONE:
  - out_valid = 1.
  - d is the full result; bout = final borrow; zero = (d == 0).
  - d, bout and zero stay stable until out_ready is sampled high.
  - On out_valid & out_ready: go to IDLE.
- Latency:
  - Operands accepted at edge k → out_valid visible after edge k + NSLICE (4 cycles for WIDTH = 16).
  - Throughput: one operation per NSLICE + 2 cycles at best.
- No overlap:
  - in_ready is 0 in RUN and DONE.
  - in_valid is ignored there, including in the cycle where the DONE handshake completes.
- Operand isolation: changes on a, b, bin after capture have no effect on the current operation.
- While out_valid = 0:
  - d shows partial contents.
  - bout and zero hold the previous result's values until DONE; consumers use them only while out_valid = 1.
- Reset mid-operation: the operation is aborted, no result is produced, and all outputs take their reset values.
- Wrap-around:
  - d is modulo 2^WIDTH.
  - a = 0, b = 2^WIDTH − 1, bin = 1 gives d = 0, bout = 1, zero = 1.

Test Plan:
- WIDTH = 16, a = 0x1234, b = 0x0234, bin = 0 → d = 0x1000, bout = 0, zero = 0; out_valid exactly 4 cycles after the accept edge.
- a = 0x1000, b = 0x0001, bin = 0 → d = 0x0FFF, bout = 0 (borrow crosses all slices). Then a = 0x0000, b = 0x0001 → d = 0xFFFF, bout = 1.
- a = 0x8000, b = 0x8000: with bin = 0 → d = 0x0000, zero = 1, bout = 0; with bin = 1 → d = 0xFFFF, bout = 1, zero = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE.
  - d, bout, zero and out_valid remain stable; in_ready = 0.
  - A new in_valid pulse in this window is not captured.
  - Raising out_ready → IDLE next cycle, then the next operand is accepted.
- Reset mid-RUN: assert rst_n low after 2 slices.
  - Outputs immediately take reset values and in_ready = 1.
  - The next operation a = 0x0005, b = 0x0003 → d = 0x0002, unaffected by the aborted operation.
- Random regression: 1000 random {a, b, bin} with random out_ready stalls, at WIDTH = 16 and WIDTH = 8.
  - Compare against the golden model d = (a − b − bin) mod 2^WIDTH, bout = (a < b + bin).
  - Check latency is NSLICE cycles for every operation.
